ram_sender: RTL and testbench
=============================

RAM_SENDER -- requirements
Module: ram_sender

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the byte width on the RAM and UART-tx paths.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, the RAM address width (256 locations).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the port list SHALL begin with them.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a dump.
REQ-007 abort  in  1  request to stop the dump in progress.
REQ-008 last_addr  in  ADDR_WIDTH  final address of the dump, inclusive; sampled at start.
REQ-009 mem_addr  out  ADDR_WIDTH  RAM read address.
REQ-010 mem_dout  in  DATA_WIDTH  RAM read data; synchronous read, valid one cycle after mem_addr.
REQ-011 tx_data  out  DATA_WIDTH  byte offered to the UART transmitter.
REQ-012 tx_valid  out  1  tx_data holds a byte.
REQ-013 tx_ready  in  1  the UART transmitter accepts tx_data.
REQ-014 busy  out  1  a dump is in progress.
REQ-015 done  out  1  one-cycle pulse after the last byte is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WAIT, SEND and DONE.
REQ-017 IDLE: start=1 -> capture last_addr; set address counter to 0; go to READ. start=0 -> stay in IDLE.
REQ-018 READ: drive mem_addr from the counter; go to WAIT.
REQ-019 WAIT: register mem_dout into tx_data; go to SEND.
REQ-020 SEND: hold tx_valid=1, with tx_data stable, until tx_valid&&tx_ready (handshake).
REQ-021 On handshake with counter==captured last_addr, the FSM SHALL go to DONE; on any other handshake, it SHALL increment the counter and go to READ.
REQ-022 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-023 tx_valid SHALL rise exactly 3 cycles after the cycle in which start is sampled high in IDLE.
REQ-024 After each handshake, the next tx_valid SHALL rise 3 cycles later; the module SHALL never assert tx_valid in two consecutive cycles across separate bytes.
REQ-025 tx_valid, once raised, SHALL NOT drop before its handshake, except on abort or reset.
REQ-026 The address counter SHALL be ADDR_WIDTH bits wide; last_addr=all-ones SHALL send exactly 2^ADDR_WIDTH bytes and terminate without wrapping to a second pass.
REQ-027 last_addr=0 SHALL send exactly one byte (address 0).
REQ-028 start while busy=1 SHALL be ignored; a change on last_addr during a dump SHALL have no effect.
REQ-029 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with tx_valid=0 and no done pulse.
REQ-030 If abort coincides with a handshake, the byte SHALL count as sent and the abort SHALL still take effect, with no done pulse.
REQ-031 abort in IDLE SHALL be ignored; start and abort high together in IDLE SHALL not start a dump.
REQ-032 busy SHALL be 1 in READ, WAIT, SEND and DONE, and 0 in IDLE.

Reset
REQ-033 rstn=0 SHALL immediately force state=IDLE, counter=0, mem_addr=0, tx_data=0, tx_valid=0, busy=0 and done=0, regardless of the current clock phase.
REQ-034 Reset during a dump SHALL abandon that dump; after release, the module SHALL wait for a new start.

Structure
REQ-035 The state enum and DATA_WIDTH/ADDR_WIDTH defaults SHALL live in the shared uart_pkg package.
REQ-036 The module SHALL instantiate no sub-module; start is already a one-cycle pulse from the existing edge_detector upstream.
REQ-037 The design SHALL use one registered FSM plus a registered tx_data/counter datapath; outputs SHALL be register- or state-decoded, with no combinational path from tx_ready to tx_valid.

Verification
REQ-038 RAM[0..3]=30h..33h, last_addr=3, tx_ready=1 -> bytes 30h,31h,32h,33h sent; first tx_valid 3 cycles after start; done pulses once; busy falls.
REQ-039 last_addr=0, RAM[0]=A5h -> exactly one handshake with A5h; done 1 cycle after it.
REQ-040 last_addr=FFh, RAM[i]=i -> 256 bytes 00h..FFh in order; no 257th tx_valid.
REQ-041 tx_ready held 0 for 10 cycles during byte 1 -> tx_valid stays 1 and tx_data stays stable throughout; the byte completes when tx_ready=1.
REQ-042 abort pulsed in SEND of byte 2 with tx_ready=0 -> tx_valid=0 next cycle; no done; a later start restarts from address 0.
REQ-043 rstn low mid-WAIT, then a second start during busy -> outputs zero asynchronously; the ignored start produces no extra bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side blocks: default bus widths and the
// ram_sender FSM state encoding.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_READ = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_SEND = 3'd3;
  localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/ram_sender.sv
// Dumps RAM[0..last_addr] byte by byte into a UART transmitter using a
// valid/ready handshake; one byte every READ->WAIT->SEND round trip.
module ram_sender
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  go;
  logic                  hs;
  logic                  at_last;

  // start together with abort in IDLE does not launch a dump
  assign go      = (state == ST_IDLE) && start && !abort;
  assign hs      = (state == ST_SEND) && tx_ready;
  assign at_last = (cnt == last_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_SEND;
      ST_SEND: if (tx_ready) state_nxt = at_last ? ST_DONE : ST_READ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // abort wins over everything, including a coincident handshake
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      last_q    <= '0;
      tx_data_q <= '0;
    end else begin
      if (go) begin
        cnt    <= '0;
        last_q <= last_addr;
      end
      if (state == ST_WAIT) tx_data_q <= mem_dout;
      // counter stops at last_q, so an all-ones last_addr never wraps
      if (hs && !at_last && !abort) cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  assign mem_addr = cnt;
  assign tx_data  = tx_data_q;
  assign tx_valid = (state == ST_SEND);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_ram_sender.sv
// Directed self-checking bench for ram_sender with a synchronous-read RAM model.
module tb_ram_sender;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] last_addr = '0;
  logic [7:0] mem_addr;
  logic [7:0] mem_dout = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;

  logic [7:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  logic [7:0] hs_q [$];
  int done_cnt = 0;
  int viol = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  logic prev_hs = 1'b0;

  ram_sender dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .last_addr(last_addr),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_addr];

  // Handshake/done recorder; a handshake seen here completes on the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_valid && prev_hs) viol++;
      prev_hs = tx_valid && tx_ready;
      if (prev_hs) begin
        hs_q.push_back(tx_data);
        hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    hs_q.delete();
    done_cnt = 0;
    viol = 0;
  endtask

  task automatic load_ascii();
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 4; i++) ram[i] = 8'h30 + 8'(i);
  endtask

  task automatic pulse_start(input logic [7:0] la);
    @(posedge clk); #1;
    last_addr = la;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, tx_valid, done} !== 3'b000 || mem_addr !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b addr=%h data=%h, required all zero",
               busy, tx_valid, done, mem_addr, tx_data);
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic v1, v2, v3;
    logic [7:0] d3;
    bit ok;
    load_ascii();
    tx_ready = 1'b1;
    clear_mon();
    pulse_start(8'd3);
    @(negedge clk); v1 = tx_valid;
    @(negedge clk); v2 = tx_valid;
    @(negedge clk); v3 = tx_valid; d3 = tx_data;
    checks++;
    if ({v1, v2, v3} !== 3'b001) begin
      errors++;
      $display("FAIL basic_first_valid_latency: valid over cycles 1..3=%b, required 001", {v1, v2, v3});
    end
    checks++;
    if (d3 !== 8'h30) begin
      errors++;
      $display("FAIL basic_first_byte: got %h, required 30", d3);
    end
    wait_done(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done_timeout: done not seen, required within 40 cycles");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall: busy=%b after done, required 0", busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hs_q.size() != 4) begin
      errors++;
      $display("FAIL basic_byte_count: got %0d, required 4", hs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hs_q[i] !== 8'h30 + 8'(i)) begin
          errors++;
          $display("FAIL basic_byte%0d: got %h, required %h", i, hs_q[i], 8'h30 + 8'(i));
        end
      end
    end
    checks++;
    if (done_cnt != 1 || viol != 0) begin
      errors++;
      $display("FAIL basic_done_once: done_cnt=%0d viol=%0d, required 1 and 0", done_cnt, viol);
    end
  endtask

  task automatic test_single();
    bit ok;
    ram[0] = 8'hA5;
    tx_ready = 1'b1;
    clear_mon();
    pulse_start(8'd0);
    wait_done(20, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (!ok || hs_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: done_seen=%0d bytes=%0d, required 1 and 1", ok, hs_q.size());
    end else begin
      checks++;
      if (hs_q[0] !== 8'hA5) begin
        errors++;
        $display("FAIL single_byte: got %h, required a5", hs_q[0]);
      end
      checks++;
      if (done_cyc != hs_cyc + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL single_done_timing: done at +%0d (count %0d), required +1 (count 1)",
                 done_cyc - hs_cyc, done_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    load_ascii();
    tx_ready = 1'b0;
    clear_mon();
    pulse_start(8'd3);
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid_timeout: tx_valid not seen, required within 10 cycles");
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h30) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles with valid dropped or data changed, required 0", bad);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done(40, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || hs_q.size() != 4 || hs_q[0] !== 8'h30 || hs_q[3] !== 8'h33 || viol != 0) begin
      errors++;
      $display("FAIL bp_complete: done_seen=%0d bytes=%0d viol=%0d, required 1, 4 bytes 30..33, 0",
               ok, hs_q.size(), viol);
    end
  endtask

  task automatic test_abort();
    bit ok;
    load_ascii();
    tx_ready = 1'b0;
    clear_mon();
    pulse_start(8'd3);
    wait_valid(10, ok);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    wait_valid(10, ok);
    checks++;
    if (!ok || tx_data !== 8'h31) begin
      errors++;
      $display("FAIL abort_byte2: valid=%0d data=%h, required 1 and 31", ok, tx_data);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != 0 || hs_q.size() != 1) begin
      errors++;
      $display("FAIL abort_no_done: done_cnt=%0d bytes=%0d, required 0 and 1", done_cnt, hs_q.size());
    end
    tx_ready = 1'b1;
    clear_mon();
    pulse_start(8'd3);
    wait_done(40, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || hs_q.size() != 4 || hs_q[0] !== 8'h30) begin
      errors++;
      $display("FAIL abort_restart: done_seen=%0d bytes=%0d, required 1 and 4 starting at 30", ok, hs_q.size());
    end
  endtask

  task automatic test_abort_idle();
    int any_busy;
    clear_mon();
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    any_busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_valid !== 1'b0) any_busy++;
    end
    checks++;
    if (any_busy != 0 || hs_q.size() != 0) begin
      errors++;
      $display("FAIL idle_start_abort: busy cycles=%0d bytes=%0d, required 0 and 0", any_busy, hs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int any_busy;
    load_ascii();
    tx_ready = 1'b1;
    clear_mon();
    pulse_start(8'd3);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, tx_valid, done} !== 3'b000 || mem_addr !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async: busy=%b valid=%b done=%b addr=%h data=%h, required all zero",
               busy, tx_valid, done, mem_addr, tx_data);
    end
    @(posedge clk); #1 rstn = 1'b1;
    any_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) any_busy++;
    end
    checks++;
    if (any_busy != 0) begin
      errors++;
      $display("FAIL rst_mid_wait_start: busy for %0d cycles after release, required 0", any_busy);
    end
    clear_mon();
    pulse_start(8'd3);
    @(posedge clk); #1 start = 1'b1; last_addr = 8'd0;
    @(posedge clk); #1 start = 1'b0;
    wait_done(40, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || hs_q.size() != 4 || done_cnt != 1 || hs_q[3] !== 8'h33) begin
      errors++;
      $display("FAIL rst_mid_ignored_start: done_seen=%0d bytes=%0d done_cnt=%0d, required 1, 4 ending 33, 1",
               ok, hs_q.size(), done_cnt);
    end
  endtask

  task automatic test_full();
    bit ok;
    int bad;
    int extra;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    tx_ready = 1'b1;
    clear_mon();
    pulse_start(8'hFF);
    wait_done(1200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_done_timeout: done not seen, required within 1200 cycles");
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) extra++;
    end
    checks++;
    if (hs_q.size() != 256 || extra != 0) begin
      errors++;
      $display("FAIL full_count: bytes=%0d late_valid=%0d, required 256 and 0", hs_q.size(), extra);
    end
    bad = 0;
    for (int i = 0; i < hs_q.size(); i++) if (hs_q[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0 || done_cnt != 1 || viol != 0) begin
      errors++;
      $display("FAIL full_order: out_of_order=%0d done_cnt=%0d viol=%0d, required 0 1 0", bad, done_cnt, viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_abort();
    test_abort_idle();
    test_reset_mid();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
